// File: rtl/sd_spi_host.sv
// sd_spi_host
// -----------------------------------------------------------------------------
// SPI-mode SD card host engine. It is the initiator side of the SD SPI link,
// working for the floppy controller. It does two kinds of operation:
//   - a raw single-byte exchange;
//   - a complete command frame: index, argument and CRC, followed by R1
//     polling with 0xFF fill bytes.
// The link runs in SPI mode 0, MSB first. sd_clk idles low, MOSI changes on
// the falling edge and MISO is sampled on the rising edge.
//
// Parameters:
//   SLOW_DIV  - sd_clk half-period in clk cycles when fast=0 (card init)
//   FAST_DIV  - sd_clk half-period in clk cycles when fast=1
//   RESP_POLL - number of 0xFF poll bytes sent before a command times out
//
// Ports:
//   clk, reset_n         - system clock, asynchronous active-low reset
//   cs_assert            - 1 selects the card (sd_dat3 driven low)
//   fast                 - divider select, latched when an operation starts
//   byte_start, byte_tx  - start pulse and data for a raw byte exchange
//   cmd_start, cmd_index,
//   cmd_arg              - start pulse, index and argument of a command frame
//   byte_rx              - last byte received by a raw exchange
//   r1                   - R1 response of the last command (0xFF on timeout)
//   busy, done           - operation in progress, one-cycle completion pulse
//   timeout              - last command got no R1 (held until next cmd_start)
//   sd_clk, sd_cmd       - SPI clock and MOSI
//   sd_dat               - MISO
//   sd_dat3              - card chip select, active low
//
// Configuration macro: SD_SPI_HOST_CRC7_EN
//   Defined:   the CRC7 of every command frame is computed in hardware.
//   Undefined: the CRC byte is a constant: 0x95 for CMD0, 0x87 for CMD8,
//              and 0xFF for every other command.
// -----------------------------------------------------------------------------
module sd_spi_host #(
  parameter int SLOW_DIV  = 64,
  parameter int FAST_DIV  = 1,
  parameter int RESP_POLL = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs_assert,
  input  logic        fast,
  input  logic        byte_start,
  input  logic [7:0]  byte_tx,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  output logic [7:0]  byte_rx,
  output logic [7:0]  r1,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic        sd_clk,
  output logic        sd_cmd,
  input  logic        sd_dat,
  output logic        sd_dat3
);

  localparam int DivW  = 16;
  localparam int PollW = $clog2(RESP_POLL + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    XFER     = 3'd1,
    CMD_SEND = 3'd2,
    CMD_POLL = 3'd3,
    FINISH   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [DivW-1:0]   div_cnt_q, div_cnt_d;
  logic [3:0]        half_q, half_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic [7:0]        tx_sr_q, tx_sr_d;
  logic [7:0]        rx_sr_q, rx_sr_d;
  logic [2:0]        byte_idx_q, byte_idx_d;
  logic [PollW-1:0]  poll_q, poll_d;
  logic [5:0]        idx_q, idx_d;
  logic [31:0]       arg_q, arg_d;
  logic [7:0]        byte_rx_q, byte_rx_d;
  logic [7:0]        r1_q, r1_d;
  logic              timeout_q, timeout_d;
  logic              done_q, done_d;
  logic              cs_n_q, cs_n_d;

  logic              active;
  logic              tick;
  logic              byte_end;
  logic [2:0]        next_idx;
  logic [7:0]        frame_byte;
  logic [7:0]        crc_byte;
  logic              load_en;
  logic [7:0]        load_byte;

  // A tick marks the end of one sd_clk half-period. A byte ends on the
  // falling edge of its 16th half-period. The rising edge before that has
  // already shifted the last MISO bit into rx_sr_q.
  assign active   = (state_q == XFER) || (state_q == CMD_SEND) || (state_q == CMD_POLL);
  assign tick     = active && (div_cnt_q == (div_q - DivW'(1)));
  assign byte_end = tick && sclk_q && (half_q == 4'd15);

`ifdef SD_SPI_HOST_CRC7_EN
  // Bitwise CRC7 over the 40 bits {01, index, argument}.
  // Polynomial x^7 + x^3 + 1, register initialised to zero.
  function automatic logic [6:0] crc7(input logic [39:0] data);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb = data[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) begin
        c = c ^ 7'h09;
      end
    end
    return c;
  endfunction

  assign crc_byte = {crc7({2'b01, idx_q, arg_q}), 1'b1};
`else
  // Without the CRC engine, only the two commands a card checks in SPI mode
  // get a valid CRC byte.
  assign crc_byte = (idx_q == 6'd0) ? 8'h95 :
                    (idx_q == 6'd8) ? 8'h87 : 8'hFF;
`endif

  // Selects the frame byte that follows the one now on the wire.
  always_comb begin
    next_idx = byte_idx_q + 3'd1;
    case (next_idx)
      3'd1:    frame_byte = arg_q[31:24];
      3'd2:    frame_byte = arg_q[23:16];
      3'd3:    frame_byte = arg_q[15:8];
      3'd4:    frame_byte = arg_q[7:0];
      3'd5:    frame_byte = crc_byte;
      default: frame_byte = 8'hFF;
    endcase
  end

  // Next-state logic. The bit engine runs first. The FSM then overrides it
  // when a byte ends, so that the next byte's MSB goes out on the same
  // falling edge and there is no gap between bytes.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    div_cnt_d  = div_cnt_q;
    half_d     = half_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    byte_idx_d = byte_idx_q;
    poll_d     = poll_q;
    idx_d      = idx_q;
    arg_d      = arg_q;
    byte_rx_d  = byte_rx_q;
    r1_d       = r1_q;
    timeout_d  = timeout_q;
    done_d     = 1'b0;
    cs_n_d     = cs_n_q;
    load_en    = 1'b0;
    load_byte  = 8'hFF;

    if (active) begin
      if (tick) begin
        div_cnt_d = '0;
        half_d    = half_q + 4'd1;
        sclk_d    = ~sclk_q;
        if (!sclk_q) begin
          rx_sr_d = {rx_sr_q[6:0], sd_dat};
        end else if (half_q != 4'd15) begin
          tx_sr_d = {tx_sr_q[6:0], 1'b1};
          mosi_d  = tx_sr_q[6];
        end
      end else begin
        div_cnt_d = div_cnt_q + DivW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        cs_n_d = ~cs_assert;
        if (cmd_start || byte_start) begin
          div_d = fast ? DivW'(FAST_DIV) : DivW'(SLOW_DIV);
        end
        if (cmd_start) begin
          state_d    = CMD_SEND;
          idx_d      = cmd_index;
          arg_d      = cmd_arg;
          byte_idx_d = 3'd0;
          timeout_d  = 1'b0;
          load_en    = 1'b1;
          load_byte  = {2'b01, cmd_index};
        end else if (byte_start) begin
          state_d   = XFER;
          load_en   = 1'b1;
          load_byte = byte_tx;
        end
      end
      XFER: begin
        if (byte_end) begin
          byte_rx_d = rx_sr_q;
          mosi_d    = 1'b1;
          state_d   = FINISH;
        end
      end
      CMD_SEND: begin
        if (byte_end) begin
          load_en = 1'b1;
          if (byte_idx_q == 3'd5) begin
            state_d   = CMD_POLL;
            poll_d    = '0;
            load_byte = 8'hFF;
          end else begin
            byte_idx_d = next_idx;
            load_byte  = frame_byte;
          end
        end
      end
      CMD_POLL: begin
        if (byte_end) begin
          if (!rx_sr_q[7]) begin
            r1_d      = rx_sr_q;
            timeout_d = 1'b0;
            mosi_d    = 1'b1;
            state_d   = FINISH;
          end else if (poll_q == PollW'(RESP_POLL - 1)) begin
            r1_d      = 8'hFF;
            timeout_d = 1'b1;
            mosi_d    = 1'b1;
            state_d   = FINISH;
          end else begin
            poll_d    = poll_q + PollW'(1);
            load_en   = 1'b1;
            load_byte = 8'hFF;
          end
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load_en) begin
      tx_sr_d   = load_byte;
      mosi_d    = load_byte[7];
      div_cnt_d = '0;
      half_d    = 4'd0;
      sclk_d    = 1'b0;
    end
  end

  // State and datapath registers. Reset aborts any bus activity at once and
  // returns the pins to their idle levels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      div_q      <= '0;
      div_cnt_q  <= '0;
      half_q     <= 4'd0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b1;
      tx_sr_q    <= 8'hFF;
      rx_sr_q    <= 8'hFF;
      byte_idx_q <= 3'd0;
      poll_q     <= '0;
      idx_q      <= 6'd0;
      arg_q      <= 32'd0;
      byte_rx_q  <= 8'hFF;
      r1_q       <= 8'hFF;
      timeout_q  <= 1'b0;
      done_q     <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      div_cnt_q  <= div_cnt_d;
      half_q     <= half_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      byte_idx_q <= byte_idx_d;
      poll_q     <= poll_d;
      idx_q      <= idx_d;
      arg_q      <= arg_d;
      byte_rx_q  <= byte_rx_d;
      r1_q       <= r1_d;
      timeout_q  <= timeout_d;
      done_q     <= done_d;
      cs_n_q     <= cs_n_d;
    end
  end

  // busy also covers FINISH. It therefore falls in the same cycle that the
  // registered done pulse appears.
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign byte_rx = byte_rx_q;
  assign r1      = r1_q;
  assign timeout = timeout_q;
  assign sd_clk  = sclk_q;
  assign sd_cmd  = mosi_q;
  assign sd_dat3 = cs_n_q;

endmodule

// File: tb/tb_sd_spi_host.sv
// tb_sd_spi_host
// -----------------------------------------------------------------------------
// Testbench for sd_spi_host.
// A small SPI card responder plays queued MISO bytes and records every MOSI
// byte. Each operation pushes its expected completion record into a queue.
// A monitor checks that record against the DUT whenever done pulses.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sd_spi_host;

  localparam int SLOW_DIV  = 64;
  localparam int FAST_DIV  = 1;
  localparam int RESP_POLL = 8;

`ifdef SD_SPI_HOST_CRC7_EN
  localparam logic [7:0] Cmd17Crc = 8'h55;
  localparam logic [7:0] Cmd55Crc = 8'h65;
`else
  localparam logic [7:0] Cmd17Crc = 8'hFF;
  localparam logic [7:0] Cmd55Crc = 8'hFF;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cs_assert;
  logic        fast;
  logic        byte_start;
  logic [7:0]  byte_tx;
  logic        cmd_start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [7:0]  byte_rx;
  logic [7:0]  r1;
  logic        busy;
  logic        done;
  logic        timeout;
  logic        sd_clk;
  logic        sd_cmd;
  logic        sd_dat;
  logic        sd_dat3;

  sd_spi_host #(
    .SLOW_DIV (SLOW_DIV),
    .FAST_DIV (FAST_DIV),
    .RESP_POLL(RESP_POLL)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cs_assert (cs_assert),
    .fast      (fast),
    .byte_start(byte_start),
    .byte_tx   (byte_tx),
    .cmd_start (cmd_start),
    .cmd_index (cmd_index),
    .cmd_arg   (cmd_arg),
    .byte_rx   (byte_rx),
    .r1        (r1),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .sd_clk    (sd_clk),
    .sd_cmd    (sd_cmd),
    .sd_dat    (sd_dat),
    .sd_dat3   (sd_dat3)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]   testId;
    logic [7:0]   expRx;
    logic [7:0]   expR1;
    logic         expTo;
    logic [31:0]  expCyc;
    logic [31:0]  startCyc;
    logic [3:0]   nMosi;
    logic [111:0] mosi;
  } exp_t;

  exp_t        expQ[$];
  exp_t        monRec;
  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  logic [7:0]  heldRx = 8'hFF;
  logic [7:0]  heldR1 = 8'hFF;
  logic        heldTo = 1'b0;

  logic [7:0]  misoQ[$];
  logic [7:0]  misoSr = 8'hFF;
  int          misoBit = 0;
  logic [7:0]  mosiLog[$];
  logic [7:0]  mosiSr = 8'hFF;
  int          mosiBit = 0;

  assign sd_dat = misoSr[7];

  always @(posedge clk) cyc++;

  // Card responder: shifts MISO on the falling sd_clk edge and takes the
  // next queued byte (or 0xFF) at each byte boundary.
  always @(negedge sd_clk) begin
    if (misoBit == 7) begin
      misoBit = 0;
      if (misoQ.size() > 0) misoSr = misoQ.pop_front();
      else misoSr = 8'hFF;
    end else begin
      misoBit++;
      misoSr = {misoSr[6:0], 1'b1};
    end
  end

  // Captures MOSI on the rising sd_clk edge, as the card does.
  always @(posedge sd_clk) begin
    mosiSr = {mosiSr[6:0], sd_cmd};
    if (mosiBit == 7) begin
      mosiBit = 0;
      mosiLog.push_back(mosiSr);
    end else begin
      mosiBit++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic loadResponder(input logic [111:0] bytes, input int n);
    misoQ.delete();
    for (int i = 0; i < n; i++) misoQ.push_back(bytes[111 - 8*i -: 8]);
    misoBit = 0;
    mosiBit = 0;
    mosiLog.delete();
    if (misoQ.size() > 0) misoSr = misoQ.pop_front();
    else misoSr = 8'hFF;
  endtask

  // Monitor: pops one expected record for every done pulse it sees.
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (expQ.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_done: got done=1, expected no completion pending");
      end else begin
        monRec = expQ.pop_front();
        checkOutput($sformatf("t%0d_latency", monRec.testId), cyc - monRec.startCyc, monRec.expCyc);
        checkOutput($sformatf("t%0d_byte_rx", monRec.testId), byte_rx, monRec.expRx);
        checkOutput($sformatf("t%0d_r1", monRec.testId), r1, monRec.expR1);
        checkOutput($sformatf("t%0d_timeout", monRec.testId), timeout, monRec.expTo);
        checkOutput($sformatf("t%0d_busy_low", monRec.testId), busy, 0);
        checkOutput($sformatf("t%0d_mosi_idle", monRec.testId), sd_cmd, 1);
        checkOutput($sformatf("t%0d_sclk_idle", monRec.testId), sd_clk, 0);
        checkOutput($sformatf("t%0d_mosi_count", monRec.testId), mosiLog.size(), monRec.nMosi);
        for (int i = 0; i < monRec.nMosi; i++) begin
          if (i < mosiLog.size())
            checkOutput($sformatf("t%0d_mosi_byte%0d", monRec.testId, i), mosiLog[i],
                        monRec.mosi[111 - 8*i -: 8]);
        end
        mosiLog.delete();
      end
    end
  end

  // Issues one operation and queues its expected completion record.
  // Command records update the held r1/timeout; raw records update byte_rx.
  task automatic applyStimulus(input logic [7:0] id, input bit isCmd, input bit alsoByte,
                               input bit fastSel, input logic [5:0] idx, input logic [31:0] arg,
                               input logic [7:0] tx, input logic [7:0] expData, input logic expTo,
                               input int expCyc, input int nMosi, input logic [111:0] mosi);
    exp_t e;
    @(negedge clk);
    fast       = fastSel;
    cmd_start  = isCmd;
    byte_start = !isCmd || alsoByte;
    cmd_index  = idx;
    cmd_arg    = arg;
    byte_tx    = tx;
    if (isCmd) begin
      heldR1 = expData;
      heldTo = expTo;
    end else begin
      heldRx = expData;
    end
    e.testId   = id;
    e.expRx    = heldRx;
    e.expR1    = heldR1;
    e.expTo    = heldTo;
    e.expCyc   = expCyc;
    e.startCyc = cyc;
    e.nMosi    = 4'(nMosi);
    e.mosi     = mosi;
    expQ.push_back(e);
    @(negedge clk);
    cmd_start  = 1'b0;
    byte_start = 1'b0;
  endtask

  task automatic waitDone(input string name, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, done, 1);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n    = 1'b0;
    cs_assert  = 1'b0;
    fast       = 1'b1;
    byte_start = 1'b0;
    byte_tx    = 8'h00;
    cmd_start  = 1'b0;
    cmd_index  = 6'd0;
    cmd_arg    = 32'd0;

    repeat (3) @(negedge clk);
    checkOutput("rst_sd_clk", sd_clk, 0);
    checkOutput("rst_sd_cmd", sd_cmd, 1);
    checkOutput("rst_sd_dat3", sd_dat3, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_timeout", timeout, 0);
    checkOutput("rst_byte_rx", byte_rx, 8'hFF);
    checkOutput("rst_r1", r1, 8'hFF);
    reset_n = 1'b1;
    cs_assert = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("cs_asserted", sd_dat3, 0);

    // Raw byte exchanges, fast then slow.
    loadResponder({8'h3C, 104'h0}, 1);
    applyStimulus(8'd2, 1'b0, 1'b0, 1'b1, 6'd0, 32'd0, 8'hA5, 8'h3C, 1'b0, 18, 1, {8'hA5, 104'h0});
    waitDone("t2_done_seen", 100);

    loadResponder({8'hC3, 104'h0}, 1);
    applyStimulus(8'd3, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 8'h5A, 8'hC3, 1'b0, 16*SLOW_DIV+2, 1, {8'h5A, 104'h0});
    waitDone("t3_done_seen", 2000);

    // CMD0: R1 arrives on the second poll byte.
    loadResponder({64'hFFFF_FFFF_FFFF_FF01, 48'h0}, 8);
    applyStimulus(8'd4, 1'b1, 1'b0, 1'b1, 6'd0, 32'd0, 8'h00, 8'h01, 1'b0, 8*16+2, 8,
                  {64'h4000_0000_0095_FFFF, 48'h0});
    waitDone("t4_done_seen", 400);

    // CMD8: R1 arrives on the first poll byte.
    loadResponder({56'hFF_FFFF_FFFF_FF01, 56'h0}, 7);
    applyStimulus(8'd5, 1'b1, 1'b0, 1'b1, 6'd8, 32'h0000_01AA, 8'h00, 8'h01, 1'b0, 7*16+2, 7,
                  {56'h48_0000_01AA_87FF, 56'h0});
    waitDone("t5_done_seen", 400);

    // CMD17: R1 of 0x00 arrives on the third poll byte.
    loadResponder({72'hFF_FFFF_FFFF_FFFF_FF00, 40'h0}, 9);
    applyStimulus(8'd6, 1'b1, 1'b0, 1'b1, 6'd17, 32'd0, 8'h00, 8'h00, 1'b0, 9*16+2, 9,
                  {8'h51, 32'h0, Cmd17Crc, 24'hFF_FFFF, 40'h0});
    waitDone("t6_done_seen", 400);

    // CMD55 with MISO held high: exactly RESP_POLL poll bytes, then timeout.
    loadResponder(112'h0, 0);
    applyStimulus(8'd7, 1'b1, 1'b0, 1'b1, 6'd55, 32'd0, 8'h00, 8'hFF, 1'b1, 14*16+2, 14,
                  {8'h77, 32'h0, Cmd55Crc, 64'hFFFF_FFFF_FFFF_FFFF});
    waitDone("t7_done_seen", 600);

    // A raw byte must leave timeout and r1 exactly as they were.
    loadResponder({8'h7E, 104'h0}, 1);
    applyStimulus(8'd8, 1'b0, 1'b0, 1'b1, 6'd0, 32'd0, 8'h81, 8'h7E, 1'b0, 18, 1, {8'h81, 104'h0});
    waitDone("t8_done_seen", 100);

    // cmd_start and byte_start in the same cycle: the command wins. A later
    // byte_start pulse while busy must also be ignored.
    loadResponder({56'hFF_FFFF_FFFF_FF01, 56'h0}, 7);
    applyStimulus(8'd9, 1'b1, 1'b1, 1'b1, 6'd0, 32'd0, 8'h33, 8'h01, 1'b0, 7*16+2, 7,
                  {56'h40_0000_0000_95FF, 56'h0});
    repeat (4) @(negedge clk);
    byte_tx    = 8'h33;
    byte_start = 1'b1;
    @(negedge clk);
    byte_start = 1'b0;
    waitDone("t9_done_seen", 400);
    repeat (40) @(negedge clk);
    checkOutput("t9_idle_after", busy, 0);

    // Reset in the middle of a slow CMD0, while sd_clk is high and MOSI is 0.
    loadResponder(112'h0, 0);
    @(negedge clk);
    fast      = 1'b0;
    cmd_index = 6'd0;
    cmd_arg   = 32'd0;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    begin
      int n;
      n = 0;
      while (!sd_clk && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    checkOutput("abort_pre_sclk", sd_clk, 1);
    checkOutput("abort_pre_mosi", sd_cmd, 0);
    checkOutput("abort_pre_busy", busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("abort_sd_dat3", sd_dat3, 1);
    checkOutput("abort_sd_clk", sd_clk, 0);
    checkOutput("abort_sd_cmd", sd_cmd, 1);
    checkOutput("abort_busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    loadResponder(112'h0, 0);
    repeat (20) @(negedge clk);
    checkOutput("abort_no_done", done, 0);

    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
